// File: rtl/saikoro_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// saikoro_pkg: state encoding and default timing for the roll sequencer.
// Rev 1.0
//-----------------------------------------------------------------------------
package saikoro_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_SPIN  = 2'd1;
   localparam state_t S_DECEL = 2'd2;
   localparam state_t S_SHOW  = 2'd3;

   localparam int unsigned DEF_FAST_DIV    = 4;
   localparam int unsigned DEF_STEP_INC    = 2;
   localparam int unsigned DEF_DECEL_STEPS = 3;
   localparam int unsigned DEF_BLINK_DIV   = 5;
   localparam int unsigned DEF_TW          = 16;

endpackage
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
//-----------------------------------------------------------------------------
// btn_sync: two-flop synchronizer plus delay flop giving press/release strobes.
// Rev 1.0
//-----------------------------------------------------------------------------
module btn_sync (
   input  logic ck,
   input  logic reset,
   input  logic btn_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge ck) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;

endmodule
`default_nettype wire

// File: rtl/saikoro_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// saikoro_ctrl: turns a push-button into spin / decelerate / show enable pulses.
// Rev 1.0
//-----------------------------------------------------------------------------
module saikoro_ctrl
   import saikoro_pkg::*;
#(
   parameter int unsigned FAST_DIV    = DEF_FAST_DIV,
   parameter int unsigned STEP_INC    = DEF_STEP_INC,
   parameter int unsigned DECEL_STEPS = DEF_DECEL_STEPS,
   parameter int unsigned BLINK_DIV   = DEF_BLINK_DIV,
   parameter int unsigned TW          = DEF_TW
) (
   input  logic ck,
   input  logic reset,
   input  logic btn,
   output logic enable,
   output logic rolling,
   output logic done,
   output logic lamp_on
);

   localparam logic [TW-1:0] c_fast_last  = TW'(FAST_DIV - 1);
   localparam logic [TW-1:0] c_int_init   = TW'(FAST_DIV + STEP_INC);
   localparam logic [TW-1:0] c_step_last  = TW'(DECEL_STEPS - 1);
   localparam logic [TW-1:0] c_blink_last = TW'(BLINK_DIV - 1);

   state_t        state_q,    state_d;
   logic [TW-1:0] timer_q,    timer_d;
   logic [TW-1:0] interval_q, interval_d;
   logic [TW-1:0] step_q,     step_d;
   logic [TW-1:0] blink_q,    blink_d;
   logic          lamp_q,     lamp_d;

   logic          w_rise;
   logic          w_fall;
   logic          w_spin_hit;
   logic          w_decel_hit;
   logic [TW:0]   w_int_sum;

   btn_sync u_btn_sync (
      .ck     (ck),
      .reset  (reset),
      .btn_i  (btn),
      .rise_o (w_rise),
      .fall_o (w_fall)
   );

   assign w_spin_hit  = (timer_q == c_fast_last);
   assign w_decel_hit = (timer_q == interval_q - TW'(1));
   // One extra bit catches overflow so the interval saturates instead of wrapping.
   assign w_int_sum   = {1'b0, interval_q} + (TW+1)'(STEP_INC);

   always_ff @(posedge ck) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         interval_q <= '0;
         step_q     <= '0;
         blink_q    <= '0;
         lamp_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         interval_q <= interval_d;
         step_q     <= step_d;
         blink_q    <= blink_d;
         lamp_q     <= lamp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      interval_d = interval_q;
      step_d     = step_q;
      blink_d    = blink_q;
      lamp_d     = lamp_q;
      case (state_q)
         S_IDLE: begin
            if (w_rise) begin
               state_d = S_SPIN;
               timer_d = '0;
            end
         end
         S_SPIN: begin
            timer_d = w_spin_hit ? '0 : timer_q + TW'(1);
            if (w_fall) begin
               state_d    = S_DECEL;
               timer_d    = '0;
               interval_d = c_int_init;
               step_d     = '0;
            end
         end
         S_DECEL: begin
            if (w_decel_hit) begin
               timer_d    = '0;
               interval_d = w_int_sum[TW] ? '1 : w_int_sum[TW-1:0];
               step_d     = step_q + TW'(1);
               if (step_q == c_step_last) begin
                  state_d = S_SHOW;
                  blink_d = '0;
                  lamp_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_SHOW: begin
            if (blink_q == c_blink_last) begin
               blink_d = '0;
               lamp_d  = ~lamp_q;
            end else begin
               blink_d = blink_q + TW'(1);
            end
            if (w_rise) begin
               state_d = S_SPIN;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      enable  = ((state_q == S_SPIN) && w_spin_hit) ||
                ((state_q == S_DECEL) && w_decel_hit);
      rolling = (state_q == S_SPIN) || (state_q == S_DECEL);
      done    = (state_q == S_SHOW);
      lamp_on = (state_q == S_SHOW) ? lamp_q : 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_saikoro_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// tb_saikoro_ctrl: directed roll scenarios plus random button traffic vs. a phase model.
// Rev 1.0
//-----------------------------------------------------------------------------
module tb_saikoro_ctrl;

   localparam int FD = 4;
   localparam int SI = 2;
   localparam int DS = 3;
   localparam int BD = 5;

   localparam int P_IDLE  = 0;
   localparam int P_SPIN  = 1;
   localparam int P_DECEL = 2;
   localparam int P_SHOW  = 3;

   logic ck = 1'b0;
   logic reset = 1'b1;
   logic btn = 1'b0;
   logic enable, rolling, done, lamp_on;

   int n_tests = 0;
   int n_fail  = 0;

   saikoro_ctrl #(
      .FAST_DIV    (FD),
      .STEP_INC    (SI),
      .DECEL_STEPS (DS),
      .BLINK_DIV   (BD),
      .TW          (16)
   ) dut (
      .ck      (ck),
      .reset   (reset),
      .btn     (btn),
      .enable  (enable),
      .rolling (rolling),
      .done    (done),
      .lamp_on (lamp_on)
   );

   always #5 ck = ~ck;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Phase model: current phase, 1-based cycle count inside it, button pipeline.
   int m_phase = P_IDLE;
   int m_n     = 1;
   bit b1 = 0, b2 = 0, b3 = 0;
   int pulse_at[DS];

   initial begin
      int acc;
      acc = 0;
      for (int i = 0; i < DS; i++) begin
         acc += FD + (i + 1) * SI;
         pulse_at[i] = acc;
      end
   end

   function automatic bit decel_pulse(input int n);
      for (int i = 0; i < DS; i++)
         if (n == pulse_at[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge ck) begin
      bit rise, fall;
      if (reset) begin
         m_phase = P_IDLE; m_n = 1;
         b1 = 0; b2 = 0; b3 = 0;
      end else begin
         rise = b2 & ~b3;
         fall = ~b2 & b3;
         case (m_phase)
            P_IDLE:  if (rise) begin m_phase = P_SPIN;  m_n = 1; end else m_n++;
            P_SPIN:  if (fall) begin m_phase = P_DECEL; m_n = 1; end else m_n++;
            P_DECEL: if (m_n == pulse_at[DS-1]) begin m_phase = P_SHOW; m_n = 1; end else m_n++;
            default: if (rise) begin m_phase = P_SPIN;  m_n = 1; end else m_n++;
         endcase
         b3 = b2; b2 = b1; b1 = btn;
      end
   end

   always @(negedge ck) begin
      bit e_en, e_roll, e_done, e_lamp;
      e_en   = (m_phase == P_SPIN && (m_n % FD) == 0) ||
               (m_phase == P_DECEL && decel_pulse(m_n));
      e_roll = (m_phase == P_SPIN) || (m_phase == P_DECEL);
      e_done = (m_phase == P_SHOW);
      e_lamp = (m_phase != P_SHOW) || ((((m_n - 1) / BD) % 2) == 0);
      check("cyc_enable",  enable,  e_en);
      check("cyc_rolling", rolling, e_roll);
      check("cyc_done",    done,    e_done);
      check("cyc_lamp",    lamp_on, e_lamp);
   end

   // Advance to the next cycle, applying inputs just after its rising edge.
   task automatic step(input logic nb, input logic nr);
      @(posedge ck);
      #1;
      btn   = nb;
      reset = nr;
      @(negedge ck);
   endtask

   // Press and hold; returns at the sample point of SPIN cycle 1.
   task automatic press_entry();
      int edges;
      step(1'b1, 1'b0);
      edges = 0;
      do begin
         step(1'b1, 1'b0);
         edges++;
      end while (rolling !== 1'b1 && edges < 10);
      check("press_to_spin_edges", edges, 3);
      check("spin1_done", done, 0);
      check("spin1_lamp", lamp_on, 1);
   endtask

   // 20 SPIN cycles; returns at DECEL cycle 1.
   task automatic spin20();
      logic [31:0] smask;
      smask = 0;
      for (int c = 1; c <= 20; c++) begin
         if (enable === 1'b1) smask |= 32'd1 << (c - 1);
         step(c < 17, 1'b0);
      end
      check("spin_pulse_mask", smask, 32'h0008_8888);
      check("decel1_rolling", rolling, 1);
   endtask

   task automatic roll(input bit poke);
      logic [31:0] dmask, lmask;
      press_entry();
      spin20();
      dmask = 0;
      for (int d = 1; d <= 24; d++) begin
         if (enable === 1'b1) dmask |= 32'd1 << (d - 1);
         if (d == 24) check("decel24_done", done, 0);
         step(poke && d >= 7 && d < 12, 1'b0);
      end
      check("decel_pulse_mask", dmask, 32'h0080_2020);
      check("show_entry_done", done, 1);
      check("show_entry_rolling", rolling, 0);
      lmask = 0;
      for (int s = 1; s <= 11; s++) begin
         if (lamp_on === 1'b1) lmask |= 32'd1 << (s - 1);
         step(1'b0, 1'b0);
      end
      check("show_lamp_pattern", lmask, 32'h0000_041F);
   endtask

   initial begin
      int cnt;
      logic b;
      int left;

      step(1'b0, 1'b0);
      check("rst_enable",  enable,  0);
      check("rst_rolling", rolling, 0);
      check("rst_done",    done,    0);
      check("rst_lamp",    lamp_on, 1);
      step(1'b0, 1'b0);

      roll(1'b0);
      roll(1'b1);

      press_entry();
      spin20();
      for (int d = 1; d <= 9; d++) step(1'b0, d == 9);
      check("decel10_rolling", rolling, 1);
      step(1'b0, 1'b0);
      check("midrst_rolling", rolling, 0);
      check("midrst_done",    done,    0);
      check("midrst_lamp",    lamp_on, 1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (enable === 1'b1) cnt++;
         step(1'b0, 1'b0);
      end
      check("midrst_no_pulses", cnt, 0);
      roll(1'b0);

      b = 1'b0;
      left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (left == 0) begin
            b = ~b;
            left = $urandom_range(1, 70);
         end
         left--;
         step(b, $urandom_range(0, 399) == 0);
      end
      step(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
